// File: rtl/lcd_timing_controller_pkg.sv
// Shared types and default timing for the LCD timing controller.
// The mode encoding matches the two STAT mode bits the CPU reads.
package lcd_timing_controller_pkg;

    typedef enum logic [1:0] {
        HBLANK     = 2'd0,
        VBLANK     = 2'd1,
        OAM_SEARCH = 2'd2,
        TRANSFER   = 2'd3
    } lcd_mode_t;

    localparam int DEF_DOTS_PER_LINE = 456;
    localparam int DEF_OAM_DOTS      = 80;
    localparam int DEF_XFER_DOTS     = 172;
    localparam int DEF_VISIBLE_LINES = 144;
    localparam int DEF_TOTAL_LINES   = 154;

endpackage

// File: rtl/lcd_timing_controller_stat_irq.sv
// STAT interrupt line: LY/LYC compare, the four enabled sources, and an edge
// detector so overlapping sources only ever raise one request.
module lcd_stat_irq
    import lcd_timing_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_enable,
    input  logic       enabled,
    input  logic [7:0] ly,
    input  logic [7:0] lyc,
    input  lcd_mode_t  mode,
    input  logic [3:0] stat_int_en,
    output logic       coincidence,
    output logic       stat_irq
);

    logic stat_line;
    logic stat_line_q;

    always_comb begin
        coincidence = (ly == lyc);
        stat_line   = enabled & ((stat_int_en[3] & coincidence)
                               | (stat_int_en[2] & (mode == OAM_SEARCH))
                               | (stat_int_en[1] & (mode == VBLANK))
                               | (stat_int_en[0] & (mode == HBLANK)));
        stat_irq    = stat_line & ~stat_line_q;
    end

    // Cleared on disable so the first line after re-enable can raise a fresh edge.
    always_ff @(posedge clk) begin
        if (reset || !lcd_enable) begin
            stat_line_q <= 1'b0;
        end else begin
            stat_line_q <= stat_line;
        end
    end

endmodule

// File: rtl/lcd_timing_controller.sv
// Dot/line timing for the background renderer: mode decode, render strobes,
// VBlank/STAT requests and CPU access windows for VRAM and OAM.
module lcd_timing_controller
    import lcd_timing_controller_pkg::*;
#(
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int OAM_DOTS      = DEF_OAM_DOTS,
    parameter int XFER_DOTS     = DEF_XFER_DOTS,
    parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
    parameter int TOTAL_LINES   = DEF_TOTAL_LINES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_int_en,
    output logic       drawline,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       vram_cpu_ok,
    output logic       oam_cpu_ok,
    output logic       frame_start
);

    localparam int DOT_W = $clog2(DOTS_PER_LINE);

    localparam logic [DOT_W-1:0] DOT_LAST     = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [DOT_W-1:0] DOT_OAM      = DOT_W'(OAM_DOTS);
    localparam logic [DOT_W-1:0] DOT_XFER_END = DOT_W'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0]       LINE_VIS     = 8'(VISIBLE_LINES);
    localparam logic [7:0]       LINE_LAST    = 8'(TOTAL_LINES - 1);

    logic [DOT_W-1:0] dot;
    logic [7:0]       line;
    logic             enabled;
    lcd_mode_t        mode_s;

    // The cycle that first sees enabled=1 is dot 0 of line 0; counting starts after it.
    always_ff @(posedge clk) begin
        if (reset || !lcd_enable) begin
            enabled <= 1'b0;
            dot     <= '0;
            line    <= '0;
        end else begin
            enabled <= 1'b1;
            if (enabled) begin
                if (dot == DOT_LAST) begin
                    dot  <= '0;
                    line <= (line == LINE_LAST) ? 8'd0 : line + 8'd1;
                end else begin
                    dot <= dot + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mode_s = HBLANK;
        if (enabled) begin
            if (line >= LINE_VIS) begin
                mode_s = VBLANK;
            end else if (dot < DOT_OAM) begin
                mode_s = OAM_SEARCH;
            end else if (dot < DOT_XFER_END) begin
                mode_s = TRANSFER;
            end else begin
                mode_s = HBLANK;
            end
        end
    end

    assign ly          = line;
    assign mode        = mode_s;
    assign drawline    = enabled && (line < LINE_VIS) && (dot == DOT_OAM);
    assign vblank_irq  = enabled && (line == LINE_VIS) && (dot == '0);
    assign frame_start = enabled && (line == 8'd0) && (dot == '0);
    assign vram_cpu_ok = !enabled || (mode_s != TRANSFER);
    assign oam_cpu_ok  = !enabled || ((mode_s != OAM_SEARCH) && (mode_s != TRANSFER));

    lcd_stat_irq u_stat_irq (
        .clk         (clk),
        .reset       (reset),
        .lcd_enable  (lcd_enable),
        .enabled     (enabled),
        .ly          (line),
        .lyc         (lyc),
        .mode        (mode_s),
        .stat_int_en (stat_int_en),
        .coincidence (coincidence),
        .stat_irq    (stat_irq)
    );

endmodule

// File: tb/tb_lcd_timing_controller.sv
// Directed bench: four controller instances share one clock so a single frame
// covers the LYC, mode-IRQ, disable and mid-frame reset scenarios side by side.
module tb_lcd_timing_controller;

    logic       clk;
    logic [3:0] rst_v;
    logic [3:0] en_v;
    logic [7:0] lyc_v [4];
    logic [3:0] sie_v [4];
    logic [3:0] drawline_v, coin_v, vbl_v, stat_v, vram_v, oam_v, fs_v;
    logic [7:0] ly_v   [4];
    logic [1:0] mode_v [4];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        lcd_timing_controller dut (
            .clk         (clk),
            .reset       (rst_v[g]),
            .lcd_enable  (en_v[g]),
            .lyc         (lyc_v[g]),
            .stat_int_en (sie_v[g]),
            .drawline    (drawline_v[g]),
            .ly          (ly_v[g]),
            .mode        (mode_v[g]),
            .coincidence (coin_v[g]),
            .vblank_irq  (vbl_v[g]),
            .stat_irq    (stat_v[g]),
            .vram_cpu_ok (vram_v[g]),
            .oam_cpu_ok  (oam_v[g]),
            .frame_start (fs_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {drawline, vblank, stat, frame_start, vram_ok, oam_ok, mode, ly, coincidence}
    function automatic logic [16:0] snap(input int i);
        return {drawline_v[i], vbl_v[i], stat_v[i], fs_v[i], vram_v[i], oam_v[i],
                mode_v[i], ly_v[i], coin_v[i]};
    endfunction

    localparam logic [16:0] IDLE_COIN0 = {4'b0000, 2'b11, 2'd0, 8'd0, 1'b0};
    localparam logic [16:0] IDLE_COIN1 = {4'b0000, 2'b11, 2'd0, 8'd0, 1'b1};

    initial begin
        int ln, dt;
        logic [1:0] exp_mode;
        int mode_err = 0, ly_err = 0, draw_err = 0, vram_err = 0, oam_err = 0;
        int vbl_err = 0, fs_err = 0, coin_err = 0, stat_a_err = 0, stat_b_err = 0;
        int n_draw_a = 0, n_fs_a = 0, n_vbl_a = 0, n_stat_a = 0, n_stat_b = 0;
        int n_vbl_d = 0, n_fs_d = 0;

        // a: LYC=5 coincidence IRQ; b: mode0+mode2 IRQ; c: lcd_enable drop; d: mid-frame reset
        rst_v = 4'b1111;
        en_v  = 4'b1111;
        lyc_v[0] = 8'd5;   sie_v[0] = 4'b1000;
        lyc_v[1] = 8'hFF;  sie_v[1] = 4'b0101;
        lyc_v[2] = 8'd0;   sie_v[2] = 4'b0000;
        lyc_v[3] = 8'hFF;  sie_v[3] = 4'b0000;
        repeat (3) tick();

        check("reset_state_a", 32'(snap(0)), 32'(IDLE_COIN0));
        check("reset_state_b", 32'(snap(1)), 32'(IDLE_COIN0));
        check("reset_state_c", 32'(snap(2)), 32'(IDLE_COIN1));
        check("reset_state_d", 32'(snap(3)), 32'(IDLE_COIN0));

        rst_v = 4'b0000;
        tick();

        for (int c = 0; c <= 70224; c++) begin
            ln = c / 456;
            if (ln == 154) ln = 0;
            dt = c % 456;
            exp_mode = (ln >= 144) ? 2'd1 : (dt < 80) ? 2'd2 : (dt < 252) ? 2'd3 : 2'd0;

            if (mode_v[0] !== exp_mode) mode_err++;
            if (ly_v[0] !== 8'(ln)) ly_err++;
            if (drawline_v[0] !== (ln < 144 && dt == 80)) draw_err++;
            if (vram_v[0] !== (exp_mode != 2'd3)) vram_err++;
            if (oam_v[0] !== (exp_mode < 2'd2)) oam_err++;
            if (vbl_v[0] !== (ln == 144 && dt == 0)) vbl_err++;
            if (fs_v[0] !== (ln == 0 && dt == 0)) fs_err++;
            if (coin_v[0] !== (ln == 5)) coin_err++;
            if (stat_v[0] !== (c == 2280)) stat_a_err++;
            if (stat_v[1] !== ((ln == 0 && dt == 0) || (ln < 144 && dt == 252))) stat_b_err++;

            n_draw_a += int'(drawline_v[0]);
            n_fs_a   += int'(fs_v[0]);
            n_vbl_a  += int'(vbl_v[0]);
            n_stat_a += int'(stat_v[0]);
            n_stat_b += int'(stat_v[1]);
            n_vbl_d  += int'(vbl_v[3]);
            n_fs_d   += int'(fs_v[3]);

            case (c)
                79:    check("draw_c79", 32'(drawline_v[0]), 32'd0);
                80:    check("draw_c80", 32'(drawline_v[0]), 32'd1);
                251:   check("vram_c251", 32'(vram_v[0]), 32'd0);
                252:   check("mode_vram_c252", 32'({mode_v[0], vram_v[0], oam_v[0]}), 32'b0011);
                536:   check("draw_c536", 32'(drawline_v[0]), 32'd1);
                992:   check("draw_c992", 32'(drawline_v[0]), 32'd1);
                2280:  check("lyc_hit_c2280", 32'({coin_v[0], stat_v[0]}), 32'b11);
                2735:  check("coin_c2735", 32'(coin_v[0]), 32'd1);
                2736:  check("coin_c2736", 32'(coin_v[0]), 32'd0);
                65664: check("vblank_c65664", 32'({vbl_v[0], mode_v[0]}), 32'b101);
                69768: check("ly_c69768", 32'(ly_v[0]), 32'd153);
                70224: check("frame_start_c70224", 32'({fs_v[0], ly_v[0]}), 32'h100);
                default: ;
            endcase

            // instance c: disable for three cycles at line 50 dot 100
            if (c == 22900) begin
                check("c_before_drop", 32'({ly_v[2], mode_v[2]}), 32'({8'd50, 2'd3}));
                en_v[2] = 1'b0;
            end
            if (c >= 22901 && c <= 22903) check("c_disabled", 32'(snap(2)), 32'(IDLE_COIN1));
            if (c == 22903) en_v[2] = 1'b1;
            if (c == 22904) check("c_reenable_fs", 32'({fs_v[2], mode_v[2], ly_v[2]}),
                                  32'({1'b1, 2'd2, 8'd0}));
            if (c == 22983) check("c_draw_early", 32'(drawline_v[2]), 32'd0);
            if (c == 22984) check("c_draw_80", 32'(drawline_v[2]), 32'd1);

            // instance d: reset at line 143 dot 300, VBlank must never follow
            if (c == 65508) begin
                check("d_before_reset", 32'({ly_v[3], mode_v[3]}), 32'({8'd143, 2'd0}));
                rst_v[3] = 1'b1;
            end
            if (c == 65509 || c == 65510) check("d_in_reset", 32'(snap(3)), 32'(IDLE_COIN0));
            if (c == 65510) rst_v[3] = 1'b0;
            if (c == 65511) check("d_after_reset", 32'({fs_v[3], mode_v[3], ly_v[3]}),
                                  32'({1'b1, 2'd2, 8'd0}));

            tick();
        end

        check("mode_sequence", 32'(mode_err), 32'd0);
        check("ly_sequence", 32'(ly_err), 32'd0);
        check("drawline_sequence", 32'(draw_err), 32'd0);
        check("vram_ok_sequence", 32'(vram_err), 32'd0);
        check("oam_ok_sequence", 32'(oam_err), 32'd0);
        check("vblank_sequence", 32'(vbl_err), 32'd0);
        check("frame_start_sequence", 32'(fs_err), 32'd0);
        check("coincidence_sequence", 32'(coin_err), 32'd0);
        check("stat_lyc_sequence", 32'(stat_a_err), 32'd0);
        check("stat_mode_sequence", 32'(stat_b_err), 32'd0);
        check("drawline_count", 32'(n_draw_a), 32'd144);
        check("frame_start_count", 32'(n_fs_a), 32'd2);
        check("vblank_count", 32'(n_vbl_a), 32'd1);
        check("stat_lyc_count", 32'(n_stat_a), 32'd1);
        check("stat_mode_count", 32'(n_stat_b), 32'd146);
        check("d_vblank_count", 32'(n_vbl_d), 32'd0);
        check("d_frame_start_count", 32'(n_fs_d), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_timing_controller.md
Name: lcd_timing_controller

Overview:
- Sequences the background renderer peripheral: owns dot/line timing, issues one `drawline` pulse per visible line, and tracks LY and the STAT mode.
- Raises VBlank and STAT interrupt requests.
- Tells the bus decoder when the CPU may touch VRAM/OAM, so that memory is shared between the CPU and the renderer.
- Sits beside the graphics peripheral on the system clock. The LCDC/STAT/LYC register decode stays in the peripheral and feeds this block as plain inputs.

Parameters:
- DOTS_PER_LINE, 456, clocks per scanline
- OAM_DOTS, 80, length of mode 2 (OAM search)
- XFER_DOTS, 172, length of mode 3 (pixel transfer); fixed, no sprite penalty
- VISIBLE_LINES, 144, lines 0..143 rendered
- TOTAL_LINES, 154, lines 144..153 are VBlank

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- lcd_enable  in  1  LCDC bit 7
- lyc  in  8  LY compare value (FF45)
- stat_int_en  in  4  STAT bits 6:3: [3]=LYC, [2]=mode2, [1]=mode1, [0]=mode0
- drawline  out  1  one-cycle pulse, renderer draws current line
- ly  out  8  current line (FF44)
- mode  out  2  STAT mode: 0 HBlank, 1 VBlank, 2 OAM, 3 transfer
- coincidence  out  1  ly == lyc
- vblank_irq  out  1  one-cycle pulse
- stat_irq  out  1  one-cycle pulse
- vram_cpu_ok  out  1  CPU may access 8000-9FFF
- oam_cpu_ok  out  1  CPU may access FE00-FE9F
- frame_start  out  1  one-cycle pulse at line 0, dot 0

Behaviour:
- State registers:
  - dot counter, width clog2(DOTS_PER_LINE)
  - line counter, 8 bits
  - enabled flag
  - stat_line_q
- All outputs are combinational from these registers, so each pulse is high in the same cycle its condition holds.
- Reset: counters = 0, enabled = 0, stat_line_q = 0. During reset and while disabled the outputs are:
  - ly = 0, mode = 0, coincidence = (lyc == 0)
  - all pulses 0
  - vram_cpu_ok = 1, oam_cpu_ok = 1
- Enable:
  - enabled <= lcd_enable each cycle.
  - The first enabled cycle has dot = 0, line = 0.
  - lcd_enable falling at any point: the next cycle returns to the disabled state, counters = 0, stat_line_q = 0.
- Counting:
  - dot increments each enabled cycle.
  - At dot = DOTS_PER_LINE-1, dot wraps to 0 and line increments.
  - At line = TOTAL_LINES-1 with dot = DOTS_PER_LINE-1, line wraps to 0.
- Mode decode:
  - line >= VISIBLE_LINES: mode 1
  - else dot < OAM_DOTS: mode 2
  - else dot < OAM_DOTS+XFER_DOTS: mode 3
  - else mode 0
- Pulses:
  - drawline = enabled & line < VISIBLE_LINES & dot == OAM_DOTS (exactly 144 per frame).
  - vblank_irq = enabled & line == VISIBLE_LINES & dot == 0.
  - frame_start = enabled & line == 0 & dot == 0.
- STAT interrupt:
  - stat_line = (en[3] & coincidence) | (en[2] & mode==2) | (en[1] & mode==1) | (en[0] & mode==0), evaluated only when enabled.
  - stat_irq = stat_line & ~stat_line_q; then stat_line_q <= stat_line.
  - Blocking: adjacent sources that overlap produce no new edge.
- lyc is sampled live. A lyc write that makes coincidence true mid-line raises stat_irq that cycle if en[3] is set.
- CPU access:
  - vram_cpu_ok = (mode != 3)
  - oam_cpu_ok = (mode != 2 & mode != 3)
  - Both are forced to 1 when disabled.
- Reset has priority over lcd_enable. Reset mid-frame aborts the frame with no further pulses.

Decomposition:
- video_types package gains:
  - enum LcdMode {HBLANK=0, VBLANK=1, OAM_SEARCH=2, TRANSFER=3}
  - default timing localparams (456/80/172/144/154)
- Sub-module lcd_stat_irq: combines the four sources, the LYC compare, and the rising-edge register. The top level holds the counters and decode.

Test Plan:
- Reset, lcd_enable=1, lyc=0xFF, en=0 -> drawline at cycles 80, 536, 992...; mode sequence 2 (0-79), 3 (80-251), 0 (252-455); vram_cpu_ok=0 only for cycles 80-251.
- Run a full frame -> vblank_irq at cycle 65664 (line 144), ly=153 at cycle 69768, frame_start at cycles 0 and 70224, exactly 144 drawline pulses.
- lyc=5, en=4'b1000 -> coincidence and stat_irq at cycle 2280 only; coincidence drops at cycle 2736; no other stat_irq in the frame.
- en=4'b0101 (mode0 + mode2) -> stat_irq at cycle 0 and at dot 252 of each visible line, none at line boundaries (blocking); none during VBlank except at line 0 dot 0 of the next frame.
- Drop lcd_enable at line 50, dot 100 for 3 cycles -> ly=0, mode=0, both cpu_ok=1, no pulses; after re-enable, frame_start fires and a drawline follows 80 cycles later.
- Assert reset at line 143, dot 300 -> no vblank_irq; the first cycle after reset (lcd_enable=1) shows ly=0, mode=2, frame_start=1.
